// File: rtl/fifo_to_wmst_tile_if.sv
`default_nettype none
// ============================================================================
// Interface : fifo_to_wmst_tile_if
// Brief     : Store-FIFO read port plus Avalon write-master command/data bus.
// Revision  : 1.0 - initial release
// ============================================================================
interface fifo_to_wmst_tile_if #(
  parameter int DW  = 32,
  parameter int XAW = 32,
  parameter int CW  = 6,
  parameter int XDW = 128
) ();

  logic           store_fifo_pop;
  logic [DW-1:0]  store_fifo_data;
  logic           store_fifo_empty;

  logic           wmst_fixed_location;
  logic [XAW-1:0] wmst_write_base;
  logic [CW-1:0]  wmst_write_length;
  logic           wmst_go;
  logic           wmst_done;
  logic           wmst_user_write_buffer;
  logic [XDW-1:0] wmst_user_buffer_data;
  logic           wmst_user_buffer_full;

  // Tile side: pops the FIFO and drives the write master.
  modport master (
    output store_fifo_pop,
    input  store_fifo_data,
    input  store_fifo_empty,
    output wmst_fixed_location,
    output wmst_write_base,
    output wmst_write_length,
    output wmst_go,
    input  wmst_done,
    output wmst_user_write_buffer,
    output wmst_user_buffer_data,
    input  wmst_user_buffer_full
  );

  // FIFO / write-master side.
  modport slave (
    input  store_fifo_pop,
    output store_fifo_data,
    output store_fifo_empty,
    input  wmst_fixed_location,
    input  wmst_write_base,
    input  wmst_write_length,
    input  wmst_go,
    output wmst_done,
    input  wmst_user_write_buffer,
    input  wmst_user_buffer_data,
    output wmst_user_buffer_full
  );

endinterface

`default_nettype wire

// File: rtl/fifo_to_wmst_tile.sv
`default_nettype none
// ============================================================================
// Module   : fifo_to_wmst_tile
// Brief    : Drains store-FIFO words, packs them into XDW-bit beats and
//            streams one contiguous region out through an Avalon write master.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_to_wmst_tile #(
  parameter int AW   = 12,
  parameter int CW   = 6,
  parameter int DW   = 32,
  parameter int XAW  = 32,
  parameter int XDW  = 128,
  parameter int WCNT = XDW / DW,
  parameter int BLEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                store_start,
  input  logic [XAW-1:0]      param_waddr,
  input  logic [AW-1:0]       param_iolen,
  output logic                store_done,
  fifo_to_wmst_tile_if.master bus
);

  localparam int HW         = $clog2(WCNT + 1);
  localparam int BEAT_BYTES = XDW / 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_PACK   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [AW-1:0]  rem_q, rem_d;
  logic [AW-1:0]  bw_q, bw_d;
  logic [AW-1:0]  popped_q, popped_d;
  logic [AW-1:0]  cap_q, cap_d;
  logic [XAW-1:0] addr_q, addr_d;
  logic [XAW-1:0] base_q, base_d;
  logic [CW-1:0]  len_q, len_d;
  logic [HW-1:0]  held_q, held_d;
  logic [XDW-1:0] beat_q, beat_d;
  logic           inflight_q, inflight_d;
  logic           go_q, go_d;
  logic           done_q, done_d;

  logic [AW-1:0]  w_bw;
  logic [AW-1:0]  w_beats;
  logic [AW-1:0]  w_bytes;
  logic [CW-1:0]  w_len;
  logic [XAW-1:0] w_step;
  logic           w_in_pack;
  logic           w_complete;
  logic           w_push;
  logic           w_last;
  logic           w_pop;
  logic [HW-1:0]  w_held_eff;

  // Burst sizing; a partial trailing beat is still written as a full beat.
  assign w_bw    = (rem_q < AW'(BLEN)) ? rem_q : AW'(BLEN);
  assign w_beats = (w_bw + AW'(WCNT - 1)) / AW'(WCNT);
  assign w_bytes = w_beats * AW'(BEAT_BYTES);
  assign w_len   = w_bytes[CW-1:0];
  assign w_step  = XAW'(w_bytes);

  assign w_in_pack  = (state_q == S_PACK);
  assign w_complete = (held_q == HW'(WCNT)) || ((held_q != '0) && (cap_q == bw_q));
  assign w_push     = w_in_pack && w_complete && !bus.wmst_user_buffer_full;
  assign w_last     = w_push && (cap_q == bw_q);
  // A beat leaving this cycle frees all lanes, so refilling can start at once.
  assign w_held_eff = w_push ? '0 : held_q;
  assign w_pop      = w_in_pack && !bus.store_fifo_empty && (popped_q < bw_q) &&
                      (({1'b0, w_held_eff} + {{HW{1'b0}}, inflight_q}) < (HW + 1)'(WCNT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (store_start) begin
          state_d = (param_iolen == '0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.wmst_done) begin
          state_d = S_PACK;
        end
      end
      S_PACK: begin
        if (w_last) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.wmst_done) begin
          state_d = (rem_q != '0) ? S_ISSUE : S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rem_d      = rem_q;
    bw_d       = bw_q;
    popped_d   = popped_q;
    cap_d      = cap_q;
    addr_d     = addr_q;
    base_d     = base_q;
    len_d      = len_q;
    held_d     = held_q;
    beat_d     = beat_q;
    inflight_d = w_pop;
    go_d       = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (store_start) begin
          rem_d  = param_iolen;
          addr_d = param_waddr;
        end
      end
      S_ISSUE: begin
        if (bus.wmst_done) begin
          go_d     = 1'b1;
          base_d   = addr_q;
          len_d    = w_len;
          bw_d     = w_bw;
          rem_d    = rem_q - w_bw;
          addr_d   = addr_q + w_step;
          popped_d = '0;
          cap_d    = '0;
        end
      end
      S_PACK: begin
        if (w_pop) begin
          popped_d = popped_q + AW'(1);
        end
        if (w_push) begin
          beat_d = '0;
          held_d = '0;
        end
        if (inflight_q) begin
          for (int k = 0; k < WCNT; k++) begin
            if (w_held_eff == HW'(k)) begin
              beat_d[k*DW +: DW] = bus.store_fifo_data;
            end
          end
          held_d = w_held_eff + HW'(1);
          cap_d  = cap_q + AW'(1);
        end
      end
      S_FINISH: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q      <= '0;
      bw_q       <= '0;
      popped_q   <= '0;
      cap_q      <= '0;
      addr_q     <= '0;
      base_q     <= '0;
      len_q      <= '0;
      held_q     <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      go_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rem_q      <= rem_d;
      bw_q       <= bw_d;
      popped_q   <= popped_d;
      cap_q      <= cap_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      len_q      <= len_d;
      held_q     <= held_d;
      beat_q     <= beat_d;
      inflight_q <= inflight_d;
      go_q       <= go_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    bus.store_fifo_pop         = w_pop;
    bus.wmst_fixed_location    = 1'b0;
    bus.wmst_write_base        = base_q;
    bus.wmst_write_length      = len_q;
    bus.wmst_go                = go_q;
    bus.wmst_user_write_buffer = w_push;
    bus.wmst_user_buffer_data  = beat_q;
    store_done                 = done_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_to_wmst_tile.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_to_wmst_tile
// Brief    : Directed bench with FIFO and write-master models around the tile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_to_wmst_tile;

  localparam int AW  = 12;
  localparam int CW  = 6;
  localparam int DW  = 32;
  localparam int XAW = 32;
  localparam int XDW = 128;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           store_start = 1'b0;
  logic [XAW-1:0] param_waddr = '0;
  logic [AW-1:0]  param_iolen = '0;
  logic           store_done;

  fifo_to_wmst_tile_if #(.DW(DW), .XAW(XAW), .CW(CW), .XDW(XDW)) bus ();

  fifo_to_wmst_tile #(
    .AW(AW), .CW(CW), .DW(DW), .XAW(XAW), .XDW(XDW), .BLEN(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .store_start(store_start),
    .param_waddr(param_waddr),
    .param_iolen(param_iolen),
    .store_done (store_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]  fifo_mem [0:63];
  int             wr_ptr = 0, rd_ptr = 0;
  logic [DW-1:0]  pend_word = '0;
  bit             pend = 0;
  bit             rand_empty = 0, full_ctl = 0, busy = 0;
  int             cyc = 0, pops = 0, pushes = 0, max_out = 0;
  int             pop_empty_err = 0, push_full_err = 0;
  int             sd_cnt = 0, t_sd = -1, t_go0 = -1, t_done_rise = -1, t_start = 0;
  int             go_cnt = 0, beats_left = 0, cnt = 0;
  logic [XAW-1:0] go_base [$];
  logic [CW-1:0]  go_len  [$];
  logic [XDW-1:0] beats   [$];

  // FIFO + write-master model: drive on the falling edge, sample 1 ns later.
  initial forever begin
    @(negedge clk);
    cyc++;
    bus.store_fifo_empty      = (rd_ptr >= wr_ptr) || (rand_empty && ($urandom_range(0, 1) == 1));
    bus.wmst_user_buffer_full = full_ctl;
    if (!bus.wmst_done && !busy) t_done_rise = cyc;
    bus.wmst_done = !busy;
    #1;
    if (rst) begin
      if (bus.store_fifo_pop) begin
        if (bus.store_fifo_empty) pop_empty_err++;
        pend_word = fifo_mem[rd_ptr];
        pend = 1;
        rd_ptr++;
        pops++;
      end
      if (bus.wmst_go) begin
        go_base.push_back(bus.wmst_write_base);
        go_len.push_back(bus.wmst_write_length);
        if (go_cnt == 0) t_go0 = cyc;
        go_cnt++;
        busy = 1;
        beats_left = int'(bus.wmst_write_length) / 16;
        cnt = 2;
      end
      if (bus.wmst_user_write_buffer) begin
        if (bus.wmst_user_buffer_full) push_full_err++;
        beats.push_back(bus.wmst_user_buffer_data);
        pushes++;
        beats_left--;
      end
      if (pops - 4 * pushes > max_out) max_out = pops - 4 * pushes;
      if (busy && beats_left <= 0) begin
        if (cnt == 0) busy = 0;
        else cnt--;
      end
      if (store_done) begin
        sd_cnt++;
        t_sd = cyc;
      end
    end
  end

  // Popped word appears on the read-data bus in the following cycle.
  initial forever begin
    @(posedge clk);
    #1;
    if (pend) begin
      bus.store_fifo_data = pend_word;
      pend = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic chk(string tag, logic [XDW-1:0] obs, logic [XDW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XDW-1:0] exp_beat(int first, int n_valid);
    logic [XDW-1:0] b;
    b = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < n_valid) b[k*DW +: DW] = DW'(first + k);
    end
    return b;
  endfunction

  task automatic load(int n, int base);
    for (int i = 0; i < n; i++) fifo_mem[i] = DW'(base + i);
    rd_ptr = 0;
    wr_ptr = n;
  endtask

  task automatic clear();
    go_base.delete();
    go_len.delete();
    beats.delete();
    pops = 0; pushes = 0; max_out = 0; go_cnt = 0; sd_cnt = 0;
    pop_empty_err = 0; push_full_err = 0; t_sd = -1; t_go0 = -1;
  endtask

  task automatic start(logic [XAW-1:0] a, logic [AW-1:0] n);
    param_waddr = a;
    param_iolen = n;
    store_start = 1'b1;
    t_start = cyc;
    tick();
    store_start = 1'b0;
  endtask

  task automatic wait_done(string tag, int limit);
    int k;
    k = 0;
    while (sd_cnt == 0 && k < limit) begin
      tick();
      k++;
    end
    chk(tag, sd_cnt != 0, 1);
  endtask

  task automatic wait_go(string tag, int n, int limit);
    int k;
    k = 0;
    while (go_cnt < n && k < limit) begin
      tick();
      k++;
    end
    chk(tag, go_cnt >= n, 1);
  endtask

  initial begin
    int stab_err;
    logic [XDW-1:0] held;
    bus.store_fifo_empty      = 1'b1;
    bus.store_fifo_data       = '0;
    bus.wmst_done             = 1'b1;
    bus.wmst_user_buffer_full = 1'b0;

    // Reset state
    tick(3);
    chk("reset_ctrl", {bus.wmst_go, bus.wmst_user_write_buffer, bus.store_fifo_pop,
                       store_done, bus.wmst_fixed_location}, 5'b0);
    chk("reset_cmd", {bus.wmst_write_base, bus.wmst_write_length}, '0);
    chk("reset_data", bus.wmst_user_buffer_data, '0);
    rst = 1'b1;
    tick(2);

    // Two full bursts
    load(16, 0);
    clear();
    start(32'h1000, 12'd16);
    wait_done("t1_done_seen", 200);
    tick(5);
    chk("t1_go_latency", t_go0 - t_start, 2);
    chk("t1_go_cnt", go_cnt, 2);
    chk("t1_go0", {go_base[0], go_len[0]}, {32'h1000, 6'd32});
    chk("t1_go1", {go_base[1], go_len[1]}, {32'h1020, 6'd32});
    chk("t1_pushes", pushes, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_beat%0d", i), beats[i], exp_beat(4 * i, 4));
    chk("t1_done_pulses", sd_cnt, 1);
    chk("t1_fixed_loc", bus.wmst_fixed_location, 0);

    // Partial trailing beat, zero padded
    load(6, 0);
    clear();
    start(32'h2000, 12'd6);
    wait_done("t2_done_seen", 200);
    tick(3);
    chk("t2_go_cnt", go_cnt, 1);
    chk("t2_go0", {go_base[0], go_len[0]}, {32'h2000, 6'd32});
    chk("t2_pushes", pushes, 2);
    chk("t2_beat0", beats[0], exp_beat(0, 4));
    chk("t2_beat1", beats[1], 128'h00000000_00000000_00000005_00000004);
    chk("t2_done_after_wmst_done", t_sd - t_done_rise, 2);

    // Back-pressure from the write-master buffer
    load(16, 100);
    clear();
    start(32'h4000, 12'd16);
    wait_go("t3_go_seen", 1, 50);
    tick(3);
    full_ctl = 1;
    stab_err = 0;
    held = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 6) held = bus.wmst_user_buffer_data;
      if (i > 6 && bus.wmst_user_buffer_data !== held) stab_err++;
    end
    full_ctl = 0;
    wait_done("t3_done_seen", 200);
    chk("t3_push_while_full", push_full_err, 0);
    chk("t3_held_beat_stable", stab_err, 0);
    chk("t3_max_outstanding_le4", max_out <= 4, 1);
    chk("t3_pushes", pushes, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_beat%0d", i), beats[i], exp_beat(100 + 4 * i, 4));

    // Random FIFO underflow stalls across five bursts
    load(40, 0);
    clear();
    rand_empty = 1;
    start(32'h1000, 12'd40);
    wait_done("t4_done_seen", 2000);
    rand_empty = 0;
    chk("t4_go_cnt", go_cnt, 5);
    for (int n = 0; n < 5; n++)
      chk($sformatf("t4_go%0d", n), {go_base[n], go_len[n]}, {32'h1000 + 32'(32 * n), 6'd32});
    chk("t4_pushes", pushes, 10);
    for (int i = 0; i < 10; i++) chk($sformatf("t4_beat%0d", i), beats[i], exp_beat(4 * i, 4));
    chk("t4_pop_while_empty", pop_empty_err, 0);

    // Zero-length region
    load(0, 0);
    clear();
    start(32'h5000, 12'd0);
    wait_done("t5_done_seen", 20);
    chk("t5_done_latency", t_sd - t_start, 2);
    chk("t5_go_cnt", go_cnt, 0);
    chk("t5_pops", pops, 0);

    // Reset in the middle of a burst, then a clean run
    load(16, 0);
    clear();
    start(32'h6000, 12'd16);
    wait_go("t6_go_seen", 1, 50);
    tick(3);
    rst = 1'b0;
    #1;
    chk("t6_rst_ctrl", {bus.wmst_go, bus.wmst_user_write_buffer, bus.store_fifo_pop, store_done}, 4'b0);
    chk("t6_rst_cmd", {bus.wmst_write_base, bus.wmst_write_length}, '0);
    chk("t6_rst_data", bus.wmst_user_buffer_data, '0);
    busy = 0;
    pend = 0;
    load(8, 'hA0);
    clear();
    tick();
    rst = 1'b1;
    tick(3);
    chk("t6_no_done_after_abort", sd_cnt, 0);
    start(32'h3000, 12'd8);
    wait_done("t6_done_seen", 200);
    tick(4);
    chk("t6_go_cnt", go_cnt, 1);
    chk("t6_go0", {go_base[0], go_len[0]}, {32'h3000, 6'd32});
    chk("t6_pushes", pushes, 2);
    chk("t6_beat0", beats[0], exp_beat('hA0, 4));
    chk("t6_beat1", beats[1], exp_beat('hA4, 4));
    chk("t6_done_pulses", sd_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_to_wmst_tile.md
Name: fifo_to_wmst_tile

Overview:
- Store-side counterpart of the load path: drains DW-bit words from the store FIFO filled by the compute logic.
- Packs WCNT words into XDW-bit beats and drives the Avalon write master (wmst_*) in bursts of up to BLEN words.
- Streams one contiguous region of param_iolen words to external memory at param_waddr, then pulses store_done.

Parameters:
- AW, 12, word-count width (param_iolen, counters)
- CW, 6, write-length width (bytes)
- DW, 32, FIFO word width
- XAW, 32, external byte-address width
- XDW, 128, write-master beat width
- WCNT, XDW/DW, words per beat (4)
- BLEN, 8, max words per burst; BLEN multiple of WCNT; BLEN*4 < 2^CW

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- store_start  in  1  one-cycle start pulse; latches param_waddr and param_iolen
- param_waddr  in  XAW  byte base address, 16-byte aligned
- param_iolen  in  AW  number of words to store
- store_done  out  1  one-cycle pulse when the region has been handed to the master
- store_fifo_pop  out  1  pop request to store FIFO
- store_fifo_data  in  DW  FIFO read data, valid the cycle after pop
- store_fifo_empty  in  1  FIFO empty
- wmst_fixed_location  out  1  constant 0
- wmst_write_base  out  XAW  burst byte address
- wmst_write_length  out  CW  burst length in bytes
- wmst_go  out  1  one-cycle burst start
- wmst_done  in  1  master idle / previous burst complete
- wmst_user_write_buffer  out  1  one-cycle beat push
- wmst_user_buffer_data  out  XDW  beat data
- wmst_user_buffer_full  in  1  master buffer full; no push while high

Behaviour:
- Reset (rst low, async): all outputs and registers 0; state IDLE.
- FSM states: IDLE, ISSUE, PACK, WAIT, FINISH.
- IDLE:
  - store_start latches waddr/iolen and sets rem=iolen.
  - If iolen==0 go to FINISH; else go to ISSUE.
  - store_start outside IDLE is ignored.
- ISSUE:
  - bw = min(rem, BLEN); beats = ceil(bw/WCNT).
  - When wmst_done==1, assert wmst_go for one cycle with wmst_write_base=cur_addr and wmst_write_length=beats*WCNT*4.
  - Then rem -= bw, cur_addr += beats*16, and go to PACK.
  - Earliest go is 2 cycles after store_start.
- PACK, pop rule:
  - store_fifo_pop = !store_fifo_empty && popped<bw && (words held + in-flight) < WCNT.
  - The pop gating makes the block never pop an empty FIFO and never pop past bw.
- PACK, packing:
  - A word captured one cycle after its pop goes into beat bits [DW*k+DW-1 : DW*k], k = word index 0..WCNT-1, LSW first.
- PACK, beat push:
  - A beat is complete when WCNT words are captured, or when the last word of the burst is captured; remaining lanes are zero-padded.
  - A complete beat drives wmst_user_write_buffer=1 for one cycle in any cycle where wmst_user_buffer_full==0, with data stable.
  - While full==1 the beat is held unchanged and pops stall once WCNT words are held or in flight.
  - Capture of the next beat's words may overlap the push cycle.
- PACK exit:
  - After the last beat of the burst is pushed: if rem>0 go to ISSUE (via WAIT), else go to WAIT then FINISH.
- WAIT: hold until wmst_done==1.
- FINISH: store_done=1 for exactly one cycle, then IDLE.
- Arithmetic:
  - rem and popped are AW bits; cur_addr is XAW bits and wraps modulo 2^XAW.
  - Padding bytes are written to memory (region rounded up to 16 bytes).
- Simultaneous pop/capture/push in the same cycle is legal; no word may be dropped or duplicated.
- Mid-operation reset aborts with no store_done; the next store_start behaves as after power-up.

Test Plan:
- iolen=16, waddr=0x1000, FIFO preloaded 0..15, full=0:
  - two wmst_go: (0x1000, 32) and (0x1020, 32).
  - four pushes; beat0=0x00000003_00000002_00000001_00000000, beat3 holds words 15..12.
  - one store_done pulse.
- iolen=6, waddr=0x2000:
  - one go (0x2000, 32).
  - beat1=0x00000000_00000000_00000005_00000004.
  - store_done after wmst_done.
- wmst_user_buffer_full forced high 10 cycles mid-burst of iolen=16:
  - no push while high; held beat data unchanged.
  - at most 4 words outstanding.
  - all 16 words arrive in order.
- store_fifo_empty toggled randomly during iolen=40:
  - beat sequence identical to the stall-free run.
  - 5 gos at 0x1000+32n.
  - no pop while empty.
- iolen=0 store_start:
  - no wmst_go and no pop.
  - store_done pulse 2 cycles after start.
- rst low for 1 cycle mid-PACK:
  - all outputs 0 immediately.
  - a new store_start with iolen=8 completes normally with one go and 2 beats.
